// File: rtl/branch_ctrl_id.sv
// ID-stage branch/jump controller: PC source select, load/ALU hazard stalls, IF/ID flush.
// Optional statistics counters built only when BRANCH_STATS_EN is defined.
module branch_ctrl_id #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             beq_id,
  input  logic             bne_id,
  input  logic             jmp_id,
  input  logic [4:0]       rs_id,
  input  logic [4:0]       rt_id,
  input  logic             operands_eq,
  input  logic             regwrite_ex,
  input  logic             memread_ex,
  input  logic [4:0]       rd_ex,
  input  logic             memread_mem,
  input  logic [4:0]       rd_mem,
  output logic [1:0]       pc_src,
  output logic             stall_if,
  output logic             bubble_id,
  output logic             flush_ifid,
  output logic [CNT_W-1:0] br_total,
  output logic [CNT_W-1:0] br_taken
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_e;

  state_e state_q, state_d;
  logic   hit_ex, hit_mem, is_br, taken, haz2, haz1, resolve;

  // Hazard classification; register 0 never conflicts.
  always_comb begin
    hit_ex  = (rd_ex != 5'd0) && ((rd_ex == rs_id) || (rd_ex == rt_id));
    hit_mem = (rd_mem != 5'd0) && ((rd_mem == rs_id) || (rd_mem == rt_id));
    is_br   = !jmp_id && (beq_id || bne_id);
    taken   = beq_id ? operands_eq : !operands_eq;
    haz2    = memread_ex && hit_ex;
    haz1    = !haz2 && ((regwrite_ex && hit_ex) || (memread_mem && hit_mem));
    resolve = (state_q == IDLE) && is_br && !haz2 && !haz1;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = IDLE;
    if ((state_q == IDLE) && is_br && haz2) state_d = HOLD;
  end

  always_comb begin
    pc_src     = 2'b00;
    stall_if   = 1'b0;
    bubble_id  = 1'b0;
    flush_ifid = 1'b0;
    if (state_q == HOLD) begin
      stall_if  = 1'b1;
      bubble_id = 1'b1;
    end else if (jmp_id) begin
      pc_src     = 2'b10;
      flush_ifid = 1'b1;
    end else if (is_br) begin
      if (haz2 || haz1) begin
        stall_if  = 1'b1;
        bubble_id = 1'b1;
      end else if (taken) begin
        pc_src     = 2'b01;
        flush_ifid = 1'b1;
      end
    end
  end

`ifdef BRANCH_STATS_EN
  logic [CNT_W-1:0] br_total_q, br_total_d, br_taken_q, br_taken_d;

  // Saturating counts of resolved and taken conditional branches.
  always_comb begin
    br_total_d = br_total_q;
    br_taken_d = br_taken_q;
    if (resolve && !(&br_total_q)) br_total_d = br_total_q + CNT_W'(1);
    if (resolve && taken && !(&br_taken_q)) br_taken_d = br_taken_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      br_total_q <= '0;
      br_taken_q <= '0;
    end else begin
      br_total_q <= br_total_d;
      br_taken_q <= br_taken_d;
    end
  end

  assign br_total = br_total_q;
  assign br_taken = br_taken_q;
`else
  logic unused_resolve;
  assign unused_resolve = resolve;
  assign br_total = '0;
  assign br_taken = '0;
`endif

endmodule

// File: tb/tb_branch_ctrl_id.sv
// Self-checking bench for branch_ctrl_id: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model.
module tb_branch_ctrl_id;

  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             beq_id, bne_id, jmp_id, operands_eq;
  logic [4:0]       rs_id, rt_id, rd_ex, rd_mem;
  logic             regwrite_ex, memread_ex, memread_mem;
  logic [1:0]       pc_src;
  logic             stall_if, bubble_id, flush_ifid;
  logic [CNT_W-1:0] br_total, br_taken;

  int n_checks = 0;
  int n_errors = 0;

  // Model: remaining forced-stall cycles and the statistics.
  int m_hold  = 0;
  int m_total = 0;
  int m_taken = 0;

  branch_ctrl_id #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .beq_id(beq_id), .bne_id(bne_id), .jmp_id(jmp_id),
    .rs_id(rs_id), .rt_id(rt_id), .operands_eq(operands_eq),
    .regwrite_ex(regwrite_ex), .memread_ex(memread_ex), .rd_ex(rd_ex),
    .memread_mem(memread_mem), .rd_mem(rd_mem),
    .pc_src(pc_src), .stall_if(stall_if), .bubble_id(bubble_id), .flush_ifid(flush_ifid),
    .br_total(br_total), .br_taken(br_taken)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit reg_match(input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b);
    return (rd != 0) && (rd == a || rd == b);
  endfunction

  // One cycle: apply inputs, compare against the model, then advance over the clock edge.
  task automatic step(input bit beq, input bit bne, input bit jmp,
                      input int rs, input int rt, input bit eq,
                      input bit rw_ex, input bit mr_ex, input int rdx,
                      input bit mr_mem, input int rdm, input bit rst);
    int exp_pc, exp_stall, exp_flush, depth, nxt_hold, sat;
    bit tk;
    beq_id = beq; bne_id = bne; jmp_id = jmp;
    rs_id = 5'(rs); rt_id = 5'(rt); operands_eq = eq;
    regwrite_ex = rw_ex; memread_ex = mr_ex; rd_ex = 5'(rdx);
    memread_mem = mr_mem; rd_mem = 5'(rdm); reset = rst;
    #2;
    exp_pc = 0; exp_stall = 0; exp_flush = 0; nxt_hold = 0;
    sat = (1 << CNT_W) - 1;
    if (m_hold > 0) begin
      exp_stall = 1;
    end else if (jmp) begin
      exp_pc = 2; exp_flush = 1;
    end else if (beq || bne) begin
      if (mr_ex && reg_match(rd_ex, rs_id, rt_id))        depth = 2;
      else if (rw_ex && reg_match(rd_ex, rs_id, rt_id))   depth = 1;
      else if (mr_mem && reg_match(rd_mem, rs_id, rt_id)) depth = 1;
      else                                                depth = 0;
      if (depth > 0) begin
        exp_stall = 1;
        nxt_hold  = depth - 1;
      end else begin
        tk = beq ? eq : !eq;
        if (tk) begin exp_pc = 1; exp_flush = 1; end
      end
    end
    check_val("pc_src", int'(pc_src), exp_pc);
    check_val("stall_if", int'(stall_if), exp_stall);
    check_val("bubble_id", int'(bubble_id), exp_stall);
    check_val("flush_ifid", int'(flush_ifid), exp_flush);
    if (stall_if && flush_ifid) check_val("stall_and_flush", 1, 0);
`ifdef BRANCH_STATS_EN
    check_val("br_total", int'(br_total), m_total);
    check_val("br_taken", int'(br_taken), m_taken);
`else
    check_val("br_total", int'(br_total), 0);
    check_val("br_taken", int'(br_taken), 0);
`endif
    @(posedge clk);
    if (rst) begin
      m_hold = 0; m_total = 0; m_taken = 0;
    end else begin
      if (m_hold == 0 && !jmp && (beq || bne) && exp_stall == 0) begin
        if (m_total < sat) m_total++;
        if ((beq ? eq : !eq) && m_taken < sat) m_taken++;
      end
      m_hold = (m_hold > 0) ? 0 : nxt_hold;
    end
    #1;
  endtask

  task automatic idle_step(input bit rst);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, rst);
  endtask

  initial begin
    reset = 1'b1;
    beq_id = 0; bne_id = 0; jmp_id = 0; operands_eq = 0;
    rs_id = 0; rt_id = 0; rd_ex = 0; rd_mem = 0;
    regwrite_ex = 0; memread_ex = 0; memread_mem = 0;
    @(posedge clk); @(posedge clk); #1;
    m_hold = 0; m_total = 0; m_taken = 0;

    idle_step(1);
    idle_step(0);
    // beq no hazard, taken; then quiet cycle
    step(1, 0, 0, 1, 2, 1, 0, 0, 0, 0, 0, 0);
    idle_step(0);
    // bne after ALU producer in EX
    step(0, 1, 0, 5, 6, 0, 1, 0, 5, 0, 0, 0);
    step(0, 1, 0, 5, 6, 0, 0, 0, 0, 0, 0, 0);
    // beq after load in EX: two stalls then not-taken
    step(1, 0, 0, 3, 7, 0, 0, 1, 7, 0, 0, 0);
    step(1, 0, 0, 3, 7, 0, 0, 0, 0, 1, 7, 0);
    step(1, 0, 0, 3, 7, 0, 0, 0, 0, 0, 0, 0);
    // load in MEM: one stall
    step(0, 1, 0, 9, 4, 1, 0, 0, 0, 1, 9, 0);
    step(0, 1, 0, 9, 4, 1, 0, 0, 0, 0, 0, 0);
    // register 0 never hazards; jump wins over beq
    step(1, 0, 0, 0, 3, 1, 1, 0, 0, 1, 0, 0);
    step(1, 0, 1, 2, 2, 1, 0, 1, 2, 0, 0, 0);
    // reset while in HOLD
    step(1, 0, 0, 6, 8, 1, 0, 1, 6, 0, 0, 0);
    step(1, 0, 0, 6, 8, 1, 0, 0, 0, 0, 0, 1);
    step(0, 1, 0, 6, 8, 0, 0, 0, 0, 0, 0, 0);
    // statistics: 3 beq resolved (2 taken), 1 jump
    idle_step(1);
    step(1, 0, 0, 1, 2, 1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 2, 1, 0, 0, 0, 0, 0, 0);
    idle_step(0);
`ifdef BRANCH_STATS_EN
    check_val("stats_total3", int'(br_total), 3);
    check_val("stats_taken2", int'(br_taken), 2);
`else
    check_val("stats_total_off", int'(br_total), 0);
    check_val("stats_taken_off", int'(br_taken), 0);
`endif

    // Randomized traffic with small register indices to provoke hazards and saturation.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 7) == 0),
           $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
           $urandom_range(0, 1), ($urandom_range(0, 3) == 0), $urandom_range(0, 3),
           ($urandom_range(0, 3) == 0), $urandom_range(0, 3), ($urandom_range(0, 199) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
